// File: rtl/tile_board_scheduler_if.sv
// Handshake and video-lookup signals between game logic, the VGA timing
// generator and the tile board scheduler.
interface tile_board_scheduler_if;
  logic [9:0] VGA_row;
  logic [9:0] VGA_col;
  logic       wr_req;
  logic [3:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_color;
  logic       wr_ack;
  logic       clear_req;
  logic       clear_ack;
  logic       tile_valid;
  logic [2:0] tile_color;
  logic       frame_start;
  logic       busy;
  logic       fifo_full;

  modport master (
    output VGA_row, VGA_col, wr_req, wr_x, wr_y, wr_color, clear_req,
    input  wr_ack, clear_ack, tile_valid, tile_color, frame_start, busy, fifo_full
  );

  modport slave (
    input  VGA_row, VGA_col, wr_req, wr_x, wr_y, wr_color, clear_req,
    output wr_ack, clear_ack, tile_valid, tile_color, frame_start, busy, fifo_full
  );
endinterface

// File: rtl/tile_board_scheduler.sv
// 10x20 tile board: tile writes and clears are queued and committed only in
// vertical blanking; active video gets a registered per-pixel tile colour.
module tile_board_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ORIGIN_ROW = 60,
  parameter int ORIGIN_COL = 240,
  parameter int TILE_H     = 20,
  parameter int TILE_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  tile_board_scheduler_if.slave   bus
);

  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int NTILES = 200;
  localparam logic [9:0] ROW_ORG = 10'(ORIGIN_ROW);
  localparam logic [9:0] COL_ORG = 10'(ORIGIN_COL);
  localparam logic [9:0] ROW_END = 10'(ORIGIN_ROW + 20 * TILE_H);
  localparam logic [9:0] COL_END = 10'(ORIGIN_COL + 10 * TILE_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  logic [2:0]    board_r [NTILES];
  logic [11:0]   fifo_r  [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          clear_pending_r;
  state_t        state_r, state_s;
  logic [7:0]    clr_addr_r;
  logic          vblank_d_r;
  logic          prev_480_r;
  logic          tile_valid_r;
  logic [2:0]    tile_color_r;

  logic          vblank_s, vb_start_s, full_s, push_s, pop_s, clr_ack_s;
  logic          clr_we_s, clr_enter_s;
  logic [3:0]    pop_x_s;
  logic [4:0]    pop_y_s;
  logic [2:0]    pop_c_s;
  logic          pop_ok_s;
  logic [7:0]    pop_addr_s;
  logic          inside_s;
  logic [9:0]    row_off_s, col_off_s;
  logic [4:0]    ty_s;
  logic [3:0]    tx_s;
  logic [7:0]    look_addr_s;

  assign vblank_s    = bus.VGA_row >= 10'd480;
  assign vb_start_s  = vblank_s && !vblank_d_r;
  assign full_s      = count_r == CW'(FIFO_DEPTH);
  assign push_s      = bus.wr_req && !full_s;
  assign clr_ack_s   = bus.clear_req && !clear_pending_r;
  assign clr_enter_s = (state_r == ST_IDLE) && (state_s == ST_CLEAR);

  assign bus.wr_ack      = push_s;
  assign bus.clear_ack   = clr_ack_s;
  assign bus.fifo_full   = full_s;
  assign bus.busy        = state_r != ST_IDLE;
  assign bus.frame_start = (bus.VGA_row == 10'd480) && !prev_480_r;
  assign bus.tile_valid  = tile_valid_r;
  assign bus.tile_color  = tile_color_r;

  assign pop_x_s    = fifo_r[rd_ptr_r][11:8];
  assign pop_y_s    = fifo_r[rd_ptr_r][7:3];
  assign pop_c_s    = fifo_r[rd_ptr_r][2:0];
  assign pop_ok_s   = (pop_x_s <= 4'd9) && (pop_y_s <= 5'd19);
  assign pop_addr_s = 8'(pop_y_s) * 8'd10 + 8'(pop_x_s);

  // Pixel-to-tile mapping; the address is forced to 0 outside the board
  assign inside_s    = (bus.VGA_row >= ROW_ORG) && (bus.VGA_row < ROW_END) &&
                       (bus.VGA_col >= COL_ORG) && (bus.VGA_col < COL_END);
  assign row_off_s   = bus.VGA_row - ROW_ORG;
  assign col_off_s   = bus.VGA_col - COL_ORG;
  assign ty_s        = 5'(row_off_s / 10'(TILE_H));
  assign tx_s        = 4'(col_off_s / 10'(TILE_W));
  assign look_addr_s = inside_s ? (8'(ty_s) * 8'd10 + 8'(tx_s)) : 8'd0;

  // Next-state and per-cycle commit strobes
  always_comb begin
    state_s  = state_r;
    clr_we_s = 1'b0;
    pop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (vb_start_s && clear_pending_r) begin
          state_s = ST_CLEAR;
        end else if (vb_start_s && (count_r != CW'(0))) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_addr_r == 8'd199) begin
          // A push landing in the final clear cycle is still drained this frame
          if ((count_r != CW'(0)) || push_s) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_DRAIN: begin
        if (vblank_s && (count_r != CW'(0))) begin
          pop_s = 1'b1;
          if ((count_r == CW'(1)) && !push_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, clear sweep address, clear flag and vblank/row history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      clr_addr_r      <= 8'd0;
      clear_pending_r <= 1'b0;
      vblank_d_r      <= 1'b1;
      prev_480_r      <= 1'b1;
    end else begin
      state_r    <= state_s;
      vblank_d_r <= vblank_s;
      prev_480_r <= bus.VGA_row == 10'd480;
      if (state_r == ST_CLEAR) begin
        clr_addr_r <= (clr_addr_r == 8'd199) ? 8'd0 : clr_addr_r + 8'd1;
      end else begin
        clr_addr_r <= 8'd0;
      end
      if (clr_enter_s) begin
        clear_pending_r <= 1'b0;
      end else if (clr_ack_s) begin
        clear_pending_r <= 1'b1;
      end else begin
        clear_pending_r <= clear_pending_r;
      end
    end
  end

  // Write FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= 12'd0;
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= {bus.wr_x, bus.wr_y, bus.wr_color};
        wr_ptr_r         <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Board commits: clear sweep has priority, out-of-range pops are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NTILES; i++) board_r[i] <= 3'd0;
    end else if (clr_we_s) begin
      board_r[clr_addr_r] <= 3'd0;
    end else if (pop_s && pop_ok_s) begin
      board_r[pop_addr_s] <= pop_c_s;
    end
  end

  // Registered lookup result for the pixel mux
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_valid_r <= 1'b0;
      tile_color_r <= 3'd0;
    end else begin
      tile_valid_r <= inside_s;
      tile_color_r <= inside_s ? board_r[look_addr_s] : 3'd0;
    end
  end

endmodule

// File: tb/tb_tile_board_scheduler.sv
// Directed bench for tile_board_scheduler: reset, deferred commit, FIFO full,
// clear ordering, out-of-range drop and asynchronous reset mid-clear.
module tb_tile_board_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_bad    = 0;

  tile_board_scheduler_if bif();

  tile_board_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int r, input int c, output logic v, output logic [2:0] col);
    bif.VGA_row = 10'(r);
    bif.VGA_col = 10'(c);
    tick();
    v   = bif.tile_valid;
    col = bif.tile_color;
  endtask

  task automatic chk_tile(input int x, input int y, input int exp);
    logic v;
    logic [2:0] c;
    lookup(60 + y * 20 + 7, 240 + x * 16 + 5, v, c);
    check_val($sformatf("tile_%0d_%0d", x, y), 32'(c), 32'(exp));
  endtask

  task automatic chk_px(input string tag, input int r, input int c, input int exp_v, input int exp_c);
    logic v;
    logic [2:0] col;
    lookup(r, c, v, col);
    check_val({tag, "_valid"}, 32'(v), 32'(exp_v));
    check_val({tag, "_color"}, 32'(col), 32'(exp_c));
  endtask

  task automatic push(input int x, input int y, input int c, output logic acked);
    bif.VGA_row  = 10'd100;
    bif.VGA_col  = 10'd0;
    bif.wr_x     = 4'(x);
    bif.wr_y     = 5'(y);
    bif.wr_color = 3'(c);
    bif.wr_req   = 1'b1;
    #1;
    acked = bif.wr_ack;
    tick();
    bif.wr_req = 1'b0;
  endtask

  // Compressed frame: 260 cycles of vblank starting at row 480, then active video
  task automatic run_frame(output int busy_n, output int fs_n);
    busy_n = 0;
    fs_n   = 0;
    bif.VGA_row = 10'd480;
    bif.VGA_col = 10'd0;
    for (int i = 0; i < 260; i++) begin
      #1;
      fs_n += int'(bif.frame_start);
      @(posedge clk);
      #1;
      if (bif.busy) busy_n++;
      bif.VGA_row = 10'(500 + (i % 20));
    end
    bif.VGA_row = 10'd100;
    tick();
  endtask

  logic ack;
  int   b, f;

  initial begin
    reset_n       = 1'b0;
    bif.VGA_row   = 10'd100;
    bif.VGA_col   = 10'd0;
    bif.wr_req    = 1'b0;
    bif.wr_x      = 4'd0;
    bif.wr_y      = 5'd0;
    bif.wr_color  = 3'd0;
    bif.clear_req = 1'b0;
    repeat (3) tick();

    // Reset values; acks remain purely combinational
    check_val("rst_valid", 32'(bif.tile_valid), 32'd0);
    check_val("rst_color", 32'(bif.tile_color), 32'd0);
    check_val("rst_fs",    32'(bif.frame_start), 32'd0);
    check_val("rst_busy",  32'(bif.busy), 32'd0);
    check_val("rst_full",  32'(bif.fifo_full), 32'd0);
    bif.wr_req = 1'b1;
    bif.clear_req = 1'b1;
    #1;
    check_val("rst_wr_ack", 32'(bif.wr_ack), 32'd1);
    check_val("rst_clr_ack", 32'(bif.clear_ack), 32'd1);
    bif.wr_req = 1'b0;
    bif.clear_req = 1'b0;
    reset_n = 1'b1;
    bif.VGA_row = 10'd100;
    tick();

    // Every tile empty, interior edges
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) chk_tile(x, y, 0);
    chk_px("above",  59, 240, 0, 0);
    chk_px("left",   60, 239, 0, 0);
    chk_px("first",  60, 240, 1, 0);
    chk_px("last",  459, 399, 1, 0);
    chk_px("below", 460, 399, 0, 0);
    chk_px("right", 459, 400, 0, 0);
    run_frame(b, f);
    check_val("fs_once", 32'(f), 32'd1);
    check_val("idle_busy", 32'(b), 32'd0);

    // Deferred write
    push(3, 5, 4, ack);
    check_val("def_ack", 32'(ack), 32'd1);
    chk_px("def_pre", 165, 290, 1, 0);
    run_frame(b, f);
    check_val("def_busy", 32'(b), 32'd1);
    check_val("fs_again", 32'(f), 32'd1);
    chk_px("def_post", 165, 290, 1, 4);

    // FIFO full: four accepted, fifth stalls until the drain frees space
    for (int k = 0; k < 4; k++) begin
      push(k, 10, k + 1, ack);
      check_val($sformatf("full_ack%0d", k), 32'(ack), 32'd1);
    end
    check_val("full_flag", 32'(bif.fifo_full), 32'd1);
    push(4, 10, 5, ack);
    check_val("full_stall", 32'(ack), 32'd0);
    chk_tile(0, 10, 0);
    run_frame(b, f);
    check_val("full_busy", 32'(b), 32'd4);
    check_val("full_clr", 32'(bif.fifo_full), 32'd0);
    push(4, 10, 5, ack);
    check_val("full_ack4", 32'(ack), 32'd1);
    push(5, 10, 6, ack);
    check_val("full_ack5", 32'(ack), 32'd1);
    run_frame(b, f);
    check_val("full_busy2", 32'(b), 32'd2);
    for (int k = 0; k < 6; k++) chk_tile(k, 10, k + 1);

    // Out-of-range entry is popped without touching the board
    push(12, 3, 5, ack);
    check_val("oor_ack", 32'(ack), 32'd1);
    run_frame(b, f);
    check_val("oor_busy", 32'(b), 32'd1);
    chk_tile(2, 4, 0);
    chk_tile(9, 3, 0);
    chk_tile(3, 5, 4);

    // Fill with colour 2, then clear followed by a write in the same frame
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) begin
        if (bif.fifo_full) run_frame(b, f);
        push(x, y, 2, ack);
      end
    run_frame(b, f);
    chk_tile(0, 0, 2);
    chk_tile(9, 19, 2);
    bif.clear_req = 1'b1;
    #1;
    check_val("clr_ack", 32'(bif.clear_ack), 32'd1);
    tick();
    check_val("clr_stall", 32'(bif.clear_ack), 32'd0);
    bif.clear_req = 1'b0;
    push(0, 0, 7, ack);
    check_val("clr_wr_ack", 32'(ack), 32'd1);
    chk_tile(4, 4, 2);
    run_frame(b, f);
    check_val("clr_busy", 32'(b), 32'd201);
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++) chk_tile(x, y, (x == 0 && y == 0) ? 7 : 0);

    // Asynchronous reset at clear address 57 with a full FIFO queued
    push(5, 5, 3, ack);
    push(9, 19, 6, ack);
    run_frame(b, f);
    chk_tile(9, 19, 6);
    for (int k = 0; k < 4; k++) push(k, 0, 1, ack);
    bif.clear_req = 1'b1;
    tick();
    bif.clear_req = 1'b0;
    bif.VGA_row = 10'd480;
    tick();
    bif.VGA_row = 10'd500;
    repeat (57) tick();
    check_val("ar_busy_pre", 32'(bif.busy), 32'd1);
    check_val("ar_full_pre", 32'(bif.fifo_full), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("ar_busy", 32'(bif.busy), 32'd0);
    check_val("ar_full", 32'(bif.fifo_full), 32'd0);
    check_val("ar_valid", 32'(bif.tile_valid), 32'd0);
    check_val("ar_color", 32'(bif.tile_color), 32'd0);
    check_val("ar_fs", 32'(bif.frame_start), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    bif.VGA_row = 10'd100;
    tick();
    check_val("ar_idle", 32'(bif.busy), 32'd0);
    chk_tile(0, 0, 0);
    chk_tile(5, 5, 0);
    chk_tile(9, 19, 0);
    chk_tile(3, 0, 0);
    run_frame(b, f);
    check_val("ar_nothing_left", 32'(b), 32'd0);
    chk_tile(1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
